// File: rtl/hazard_tracker_pkg.sv
// Shared constants for the D-stage hazard tracker: forwarding-select codes,
// Tuse encoding and default widths.
package hazard_tracker_pkg;

  localparam int AW_DEF = 5;
  localparam int TW_DEF = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Smallest Tuse wins when several flags are set.
  function automatic logic [1:0] tuse_decode(input logic f0, input logic f1, input logic f2);
    logic [1:0] res;
    res = TUSE_NONE;
    if (f0)      res = 2'd0;
    else if (f1) res = 2'd1;
    else if (f2) res = 2'd2;
    return res;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one source register: the M result when it already
// exists, else the W result, else the register file.
module hazard_fwd_sel
  import hazard_tracker_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic [AW-1:0] i_reg,
  input  logic          i_wr_m,
  input  logic [AW-1:0] i_a3_m,
  input  logic [TW-1:0] i_tnew_m,
  input  logic          i_wr_w,
  input  logic [AW-1:0] i_a3_w,
  output logic [1:0]    o_sel
);

  logic w_live;
  logic w_hit_m;
  logic w_hit_w;

  assign w_live  = (i_reg != '0);
  assign w_hit_m = w_live && i_wr_m && (i_a3_m == i_reg) && (i_tnew_m == '0);
  assign w_hit_w = w_live && i_wr_w && (i_a3_w == i_reg);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_m)      o_sel = FWD_M;
    else if (w_hit_w) o_sel = FWD_W;
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tuse/Tnew hazard unit: shadows producer info through E/M/W and derives the
// D-stage stall plus all forwarding selects combinationally.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic          tuse_rs0,
  input  logic          tuse_rs1,
  input  logic          tuse_rt0,
  input  logic          tuse_rt1,
  input  logic          tuse_rt2,
  input  logic [TW-1:0] tnew_d,
  input  logic          regwrite_d,
  input  logic [AW-1:0] a3_d,
  output logic          stall,
  output logic [1:0]    fwd_rs_d,
  output logic [1:0]    fwd_rt_d,
  output logic [1:0]    fwd_rs_e,
  output logic [1:0]    fwd_rt_e,
  output logic          fwd_rt_m
);

  // Common width for Tnew/Tuse comparisons regardless of TW.
  localparam int CW = (TW > 2) ? TW : 2;

  logic          r_wr_e, r_wr_m, r_wr_w;
  logic [AW-1:0] r_a3_e, r_a3_m, r_a3_w;
  logic [TW-1:0] r_tnew_e, r_tnew_m;
  logic [AW-1:0] r_rs_e, r_rt_e, r_rt_m;

  logic [1:0]    w_tuse_rs, w_tuse_rt;
  logic [CW-1:0] w_tuse_rs_c, w_tuse_rt_c, w_tnew_e_c, w_tnew_m_c;
  logic          w_rs_used, w_rt_used, w_stall_rs, w_stall_rt;

  assign w_tuse_rs   = tuse_decode(tuse_rs0, tuse_rs1, 1'b0);
  assign w_tuse_rt   = tuse_decode(tuse_rt0, tuse_rt1, tuse_rt2);
  assign w_tuse_rs_c = CW'(w_tuse_rs);
  assign w_tuse_rt_c = CW'(w_tuse_rt);
  assign w_tnew_e_c  = CW'(r_tnew_e);
  assign w_tnew_m_c  = CW'(r_tnew_m);

  assign w_rs_used = (w_tuse_rs != TUSE_NONE) && (rs_d != '0);
  assign w_rt_used = (w_tuse_rt != TUSE_NONE) && (rt_d != '0);

  // A producer stalls D only if its result arrives later than the consumer needs it.
  assign w_stall_rs = w_rs_used &&
    ((r_wr_e && (r_a3_e == rs_d) && (w_tnew_e_c > w_tuse_rs_c)) ||
     (r_wr_m && (r_a3_m == rs_d) && (w_tnew_m_c > w_tuse_rs_c)));
  assign w_stall_rt = w_rt_used &&
    ((r_wr_e && (r_a3_e == rt_d) && (w_tnew_e_c > w_tuse_rt_c)) ||
     (r_wr_m && (r_a3_m == rt_d) && (w_tnew_m_c > w_tuse_rt_c)));

  assign stall = w_stall_rs || w_stall_rt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_e   <= 1'b0;
      r_a3_e   <= '0;
      r_tnew_e <= '0;
      r_rs_e   <= '0;
      r_rt_e   <= '0;
      r_wr_m   <= 1'b0;
      r_a3_m   <= '0;
      r_tnew_m <= '0;
      r_rt_m   <= '0;
      r_wr_w   <= 1'b0;
      r_a3_w   <= '0;
    end else begin
      if (stall) begin
        r_wr_e   <= 1'b0;
        r_a3_e   <= '0;
        r_tnew_e <= '0;
        r_rs_e   <= '0;
        r_rt_e   <= '0;
      end else begin
        r_wr_e   <= regwrite_d && (a3_d != '0);
        r_a3_e   <= a3_d;
        r_tnew_e <= tnew_d;
        r_rs_e   <= rs_d;
        r_rt_e   <= rt_d;
      end
      r_wr_m   <= r_wr_e;
      r_a3_m   <= r_a3_e;
      r_rt_m   <= r_rt_e;
      r_tnew_m <= (r_tnew_e == '0) ? '0 : r_tnew_e - TW'(1);
      r_wr_w   <= r_wr_m;
      r_a3_w   <= r_a3_m;
    end
  end

  logic [AW-1:0] w_src [4];
  logic [1:0]    w_sel [4];

  assign w_src[0] = rs_d;
  assign w_src[1] = rt_d;
  assign w_src[2] = r_rs_e;
  assign w_src[3] = r_rt_e;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    hazard_fwd_sel #(.AW(AW), .TW(TW)) u_sel (
      .i_reg    (w_src[gi]),
      .i_wr_m   (r_wr_m),
      .i_a3_m   (r_a3_m),
      .i_tnew_m (r_tnew_m),
      .i_wr_w   (r_wr_w),
      .i_a3_w   (r_a3_w),
      .o_sel    (w_sel[gi])
    );
  end

  assign fwd_rs_d = w_sel[0];
  assign fwd_rt_d = w_sel[1];
  assign fwd_rs_e = w_sel[2];
  assign fwd_rt_e = w_sel[3];
  assign fwd_rt_m = (r_rt_m != '0) && r_wr_w && (r_a3_w == r_rt_m);

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed pipeline scenarios plus random traffic
// checked against an age-based model of in-flight producers.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, a3_d;
  logic       tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2;
  logic [1:0] tnew_d;
  logic       regwrite_d;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       fwd_rt_m;

  hazard_tracker dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs0(tuse_rs0), .tuse_rs1(tuse_rs1),
    .tuse_rt0(tuse_rt0), .tuse_rt1(tuse_rt1), .tuse_rt2(tuse_rt2),
    .tnew_d(tnew_d), .regwrite_d(regwrite_d), .a3_d(a3_d),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
  );

  always #5 clk = ~clk;

  // Each slot is the instruction that entered E at some edge; index = age
  // (0 in E, 1 in M, 2 in W). Remaining latency is derived from age.
  typedef struct {
    bit wr;
    int dst;
    int tnew;
    int rs;
    int rt;
  } ent_t;

  ent_t hist [3];
  int   checks   = 0;
  int   failures = 0;
  bit   model_ok = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int tuse_of(input bit f0, input bit f1, input bit f2);
    if (f0) return 0;
    if (f1) return 1;
    if (f2) return 2;
    return 3;
  endfunction

  function automatic int remaining(input int t, input int age);
    return (t > age) ? t - age : 0;
  endfunction

  function automatic bit hazard(input int src, input int tu);
    if (tu == 3 || src == 0) return 1'b0;
    for (int a = 0; a < 2; a++)
      if (hist[a].wr && hist[a].dst == src && remaining(hist[a].tnew, a) > tu) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    return hazard(int'(rs_d), tuse_of(tuse_rs0, tuse_rs1, 1'b0)) ||
           hazard(int'(rt_d), tuse_of(tuse_rt0, tuse_rt1, tuse_rt2));
  endfunction

  function automatic int exp_fwd(input int src);
    if (src == 0) return 0;
    if (hist[1].wr && hist[1].dst == src && remaining(hist[1].tnew, 1) == 0) return 1;
    if (hist[2].wr && hist[2].dst == src) return 2;
    return 0;
  endfunction

  task automatic set_d(input int rs, input int rt, input bit rs0, input bit rs1,
                       input bit rt0, input bit rt1, input bit rt2,
                       input int tn, input bit rw, input int a3);
    rs_d = 5'(rs); rt_d = 5'(rt);
    tuse_rs0 = rs0; tuse_rs1 = rs1;
    tuse_rt0 = rt0; tuse_rt1 = rt1; tuse_rt2 = rt2;
    tnew_d = 2'(tn); regwrite_d = rw; a3_d = 5'(a3);
  endtask

  task automatic set_nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Let outputs settle mid-cycle and compare every output against the model.
  task automatic settle();
    bit exp_m;
    #4;
    if (model_ok) begin
      exp_m = (hist[1].rt != 0) && hist[2].wr && (hist[2].dst == hist[1].rt);
      chk("stall",    int'(stall),    int'(exp_stall()));
      chk("fwd_rs_d", int'(fwd_rs_d), exp_fwd(int'(rs_d)));
      chk("fwd_rt_d", int'(fwd_rt_d), exp_fwd(int'(rt_d)));
      chk("fwd_rs_e", int'(fwd_rs_e), exp_fwd(hist[0].rs));
      chk("fwd_rt_e", int'(fwd_rt_e), exp_fwd(hist[0].rt));
      chk("fwd_rt_m", int'(fwd_rt_m), int'(exp_m));
    end
  endtask

  task automatic advance();
    bit st;
    ent_t nxt;
    st  = exp_stall();
    nxt = '{wr: regwrite_d && (a3_d != 0), dst: int'(a3_d), tnew: int'(tnew_d),
            rs: int'(rs_d), rt: int'(rt_d)};
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0, 0};
      model_ok = 1'b1;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = st ? '{0, 0, 0, 0, 0} : nxt;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_nop();
    #1;
    settle(); advance();
    settle(); advance();
    reset = 1'b0;

    $display("scenario 1: lw $8 -> add rs=$8");
    set_d(0, 0, 0, 0, 0, 0, 0, 2, 1, 8); settle(); advance();
    set_d(8, 0, 0, 1, 0, 0, 0, 1, 1, 3); settle(); chk("s1_stall_c1", int'(stall), 1); advance();
    settle(); chk("s1_stall_c2", int'(stall), 0); advance();
    set_nop(); settle(); chk("s1_fwd_rs_e", int'(fwd_rs_e), 2); advance();

    $display("scenario 2: lw $8 -> beq rs=$8");
    set_d(0, 0, 0, 0, 0, 0, 0, 2, 1, 8); settle(); advance();
    set_d(8, 0, 1, 0, 0, 0, 0, 0, 0, 0); settle(); chk("s2_stall_c1", int'(stall), 1); advance();
    settle(); chk("s2_stall_c2", int'(stall), 1); advance();
    settle(); chk("s2_stall_c3", int'(stall), 0); chk("s2_fwd_rs_d", int'(fwd_rs_d), 2); advance();

    $display("scenario 3: add $9 -> beq rt=$9");
    set_d(0, 0, 0, 0, 0, 0, 0, 1, 1, 9); settle(); advance();
    set_d(0, 9, 0, 0, 1, 0, 0, 0, 0, 0); settle(); chk("s3_stall_c1", int'(stall), 1); advance();
    settle(); chk("s3_stall_c2", int'(stall), 0); chk("s3_fwd_rt_d", int'(fwd_rt_d), 1); advance();

    $display("scenario 4: lw $10 -> sw rt=$10");
    set_d(0, 0, 0, 0, 0, 0, 0, 2, 1, 10); settle(); advance();
    set_d(0, 10, 0, 1, 0, 0, 1, 0, 0, 0); settle(); chk("s4_stall", int'(stall), 0); advance();
    set_nop(); settle(); chk("s4_fwd_rt_e", int'(fwd_rt_e), 0); advance();
    settle(); chk("s4_fwd_rt_m", int'(fwd_rt_m), 1); advance();

    $display("scenario 5: writes to $0");
    set_d(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); settle(); advance();
    set_d(0, 0, 1, 0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("s5_stall", int'(stall), 0);
      chk("s5_fwd_any", int'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
      advance();
    end

    $display("scenario 6: reset during stall");
    set_d(0, 0, 0, 0, 0, 0, 0, 2, 1, 8); settle(); advance();
    set_d(8, 0, 1, 0, 0, 0, 0, 0, 0, 0); settle(); chk("s6_stall_pre", int'(stall), 1);
    reset = 1'b1; advance(); reset = 1'b0;
    settle();
    chk("s6_stall", int'(stall), 0);
    chk("s6_fwd_any", int'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
    chk("s6_wr_regs", int'({dut.r_wr_e, dut.r_wr_m, dut.r_wr_w}), 0);
    advance();

    $display("random traffic: 600 cycles");
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      set_d(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, 3)));
      settle();
      advance();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
